ex_div_sequencer: RTL and testbench

Multi-cycle integer divide controller for the execute stage. It accepts RV64M DIV/DIVU/REM/REMU and word variants (DIVW/DIVUW/REMW/REMUW) from issue logic and runs an iterative restoring divider, one quotient bit per cycle. It holds off new requests while busy and presents one result to the memory-stage handoff under a valid/ready handshake. It replaces single-cycle divide in the EX datapath; the EX stage stalls on `req_ready` low.

---
 rtl/ex_div_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ex_div_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_sequencer.sv
// ---------------------------------------------------------------------------
// ex_div_sequencer
//
// Multi-cycle integer divide controller for the execute stage. Accepts
// RV64M DIV/DIVU/REM/REMU and the word variants DIVW/DIVUW/REMW/REMUW and
// runs an iterative restoring divider that retires one quotient bit per
// cycle. New requests are held off while an operation is in flight, and
// one result is handed to the memory stage under a valid/ready handshake.
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous active-high reset
//   req_valid     in   divide request present
//   req_ready     out  block can accept a request (state is IDLE)
//   dividend      in   rs1 value
//   divisor       in   operand2 value (register or immediate)
//   is_word_op    in   1 = 32-bit W variant
//   unsigned_op   in   3'd1 = unsigned, any other value = signed
//   want_rem      in   1 = remainder, 0 = quotient
//   dst_reg       in   destination register carried with the request
//   flush         in   abort any in-flight operation
//   resp_valid    out  result valid
//   resp_ready    in   downstream accepts the result
//   result        out  quotient or remainder
//   resp_dst_reg  out  destination register of the result
//   busy          out  state is not IDLE
// ---------------------------------------------------------------------------
module ex_div_sequencer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_word_op,
  input  logic [2:0]            unsigned_op,
  input  logic                  want_rem,
  input  logic [4:0]            dst_reg,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            resp_dst_reg,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Sign-extend a 32-bit value to 64 bits.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Two's complement negation.
  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

  // Architectural and working state
  state_e      state_q,      state_d;
  logic [6:0]  cnt_q,        cnt_d;
  logic [63:0] quo_q,        quo_d;      // holds dividend, then quotient bits
  logic [63:0] rem_q,        rem_d;      // partial remainder
  logic [63:0] dvs_q,        dvs_d;      // divisor (raw, then magnitude)
  logic        word_q,       word_d;
  logic        signed_q,     signed_d;
  logic        rem_sel_q,    rem_sel_d;
  logic        qneg_q,       qneg_d;
  logic        rneg_q,       rneg_d;
  logic [4:0]  dst_q,        dst_d;
  logic [63:0] result_q,     result_d;
  logic        resp_valid_q, resp_valid_d;
  logic [4:0]  resp_dst_q,   resp_dst_d;
  logic        req_ready_q,  req_ready_d;
  logic        busy_q,       busy_d;

  // Combinational helpers
  logic [63:0] op_a_s;
  logic [63:0] op_b_s;
  logic [63:0] a_mag_s;
  logic [63:0] b_mag_s;
  logic [63:0] min_val_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic [64:0] rem_shift_s;
  logic [64:0] trial_s;
  logic [63:0] q_fix_s;
  logic [63:0] r_fix_s;
  logic [63:0] sel_s;
  logic [63:0] fix_res_s;

  // Operand preparation, the divide step and sign fixup datapath.
  always_comb begin
    if (word_q) begin
      op_a_s    = signed_q ? sext32(quo_q[31:0]) : {32'h0, quo_q[31:0]};
      op_b_s    = signed_q ? sext32(dvs_q[31:0]) : {32'h0, dvs_q[31:0]};
      min_val_s = 64'hFFFF_FFFF_8000_0000;
    end else begin
      op_a_s    = quo_q;
      op_b_s    = dvs_q;
      min_val_s = 64'h8000_0000_0000_0000;
    end

    // The most negative value maps onto itself, which is also its correct
    // unsigned magnitude, so no special handling is needed here.
    a_mag_s = (signed_q && op_a_s[63]) ? neg64(op_a_s) : op_a_s;
    b_mag_s = (signed_q && op_b_s[63]) ? neg64(op_b_s) : op_b_s;

    div_zero_s = (op_b_s == 64'h0);
    ovf_s      = signed_q && (op_a_s == min_val_s) &&
                 (op_b_s == 64'hFFFF_FFFF_FFFF_FFFF);

    // The partial remainder is always below the divisor, so after the shift
    // it is below twice the divisor and the 65-bit difference cannot wrap:
    // bit 64 is a reliable "negative" flag.
    rem_shift_s = {rem_q, quo_q[63]};
    trial_s     = rem_shift_s - {1'b0, dvs_q};

    q_fix_s   = qneg_q ? neg64(quo_q) : quo_q;
    r_fix_s   = rneg_q ? neg64(rem_q) : rem_q;
    sel_s     = rem_sel_q ? r_fix_s : q_fix_s;
    // W variants always sign-extend bit 31, unsigned ones included.
    fix_res_s = word_q ? sext32(sel_s[31:0]) : sel_s;
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvs_d        = dvs_q;
    word_d       = word_q;
    signed_d     = signed_q;
    rem_sel_d    = rem_sel_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    dst_d        = dst_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
    resp_dst_d   = resp_dst_q;

    case (state_q)
      ST_IDLE: begin
        resp_valid_d = 1'b0;
        if (req_valid) begin
          quo_d     = dividend;
          dvs_d     = divisor;
          word_d    = is_word_op;
          signed_d  = (unsigned_op != 3'd1);
          rem_sel_d = want_rem;
          dst_d     = dst_reg;
          state_d   = ST_PREP;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_PREP: begin
        if (div_zero_s) begin
          // Remainder of a divide by zero is the dividend; the W form is
          // sign-extended from bit 31 even for REMUW.
          result_d     = rem_sel_q ? (word_q ? sext32(quo_q[31:0]) : quo_q)
                                   : 64'hFFFF_FFFF_FFFF_FFFF;
          resp_valid_d = 1'b1;
          resp_dst_d   = dst_q;
          state_d      = ST_DONE;
        end else if (ovf_s) begin
          result_d     = rem_sel_q ? 64'h0 : op_a_s;
          resp_valid_d = 1'b1;
          resp_dst_d   = dst_q;
          state_d      = ST_DONE;
        end else begin
          // Word operands are left-aligned so the MSB-first loop sees the
          // 32 significant bits first and leaves the quotient in bits 31:0.
          quo_d   = word_q ? {a_mag_s[31:0], 32'h0} : a_mag_s;
          dvs_d   = b_mag_s;
          rem_d   = 64'h0;
          cnt_d   = word_q ? 7'd32 : 7'd64;
          qneg_d  = signed_q && (op_a_s[63] ^ op_b_s[63]);
          rneg_d  = signed_q && op_a_s[63];
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (trial_s[64]) begin
          rem_d = rem_shift_s[63:0];
          quo_d = {quo_q[62:0], 1'b0};
        end else begin
          rem_d = trial_s[63:0];
          quo_d = {quo_q[62:0], 1'b1};
        end
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d = ST_FIXUP;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FIXUP: begin
        result_d     = fix_res_s;
        resp_valid_d = 1'b1;
        resp_dst_d   = dst_q;
        state_d      = ST_DONE;
      end

      ST_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end

      default: begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // A redirect kills whatever is in flight, including a pending result.
    if (flush) begin
      state_d      = ST_IDLE;
      resp_valid_d = 1'b0;
    end else begin
      state_d      = state_d;
    end

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 7'd0;
      quo_q        <= 64'h0;
      rem_q        <= 64'h0;
      dvs_q        <= 64'h0;
      word_q       <= 1'b0;
      signed_q     <= 1'b0;
      rem_sel_q    <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      dst_q        <= 5'd0;
      result_q     <= 64'h0;
      resp_valid_q <= 1'b0;
      resp_dst_q   <= 5'd0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvs_q        <= dvs_d;
      word_q       <= word_d;
      signed_q     <= signed_d;
      rem_sel_q    <= rem_sel_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      dst_q        <= dst_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      resp_dst_q   <= resp_dst_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign result       = result_q;
  assign resp_dst_reg = resp_dst_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ex_div_sequencer
//
// Self-checking bench for ex_div_sequencer. Each request pushes its expected
// result, destination and response latency onto a scoreboard queue; the
// entry is popped and compared when the DUT raises resp_valid. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ex_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        is_word_op;
  logic [2:0]  unsigned_op;
  logic        want_rem;
  logic [4:0]  dst_reg;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] result;
  logic [4:0]  resp_dst_reg;
  logic        busy;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  dst;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  ex_div_sequencer #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .is_word_op   (is_word_op),
    .unsigned_op  (unsigned_op),
    .want_rem     (want_rem),
    .dst_reg      (dst_reg),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .result       (result),
    .resp_dst_reg (resp_dst_reg),
    .busy         (busy)
  );

  // Reference divide built on the simulator's own / and % operators.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic w, input logic [2:0] u, input logic r);
    logic               uns;
    logic [31:0]        r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    logic [63:0]        r64;
    uns = (u == 3'd1);
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'h0)
        r32 = r ? a[31:0] : 32'hFFFF_FFFF;
      else if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = r ? 32'h0 : a[31:0];
      else if (uns)
        r32 = r ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      else
        r32 = r ? (sa32 % sb32) : (sa32 / sb32);
      return {{32{r32[31]}}, r32};
    end else begin
      sa64 = a;
      sb64 = b;
      if (b == 64'h0)
        r64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
        r64 = r ? 64'h0 : a;
      else if (uns)
        r64 = r ? (a % b) : (a / b);
      else
        r64 = r ? (sa64 % sb64) : (sa64 / sb64);
      return r64;
    end
  endfunction

  // Expected cycle (relative to the accept cycle T) where resp_valid first rises.
  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic w, input logic [2:0] u);
    logic uns;
    uns = (u == 3'd1);
    if (w) begin
      if (b[31:0] == 32'h0 || (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
        return 2;
      return 35;
    end
    if (b == 64'h0 || (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF))
      return 2;
    return 67;
  endfunction

  // Present a request (called at a falling edge), wait for acceptance, push
  // the expectation and scramble the inputs so later changes are exercised.
  // Returns at the falling edge of cycle T+1.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w,
                       input logic [2:0] u, input logic r, input logic [4:0] d,
                       input logic [63:0] exp_res, input int exp_lat);
    exp_t e;
    int   guard;
    dividend    = a;
    divisor     = b;
    is_word_op  = w;
    unsigned_op = u;
    want_rem    = r;
    dst_reg     = d;
    req_valid   = 1'b1;
    guard       = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    e.res = exp_res;
    e.dst = d;
    e.lat = exp_lat;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid   = 1'b0;
    dividend    = ~a;
    divisor     = ~b;
    is_word_op  = ~w;
    unsigned_op = u ^ 3'd1;
    want_rem    = ~r;
    dst_reg     = ~d;
  endtask

  // Count falling edges until resp_valid; lat = n means seen in cycle T+n.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!resp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    dividend = 64'h0; divisor = 64'h0; is_word_op = 1'b0; unsigned_op = 3'd0;
    want_rem = 1'b0; dst_reg = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests_run++; if (result !== 64'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", result); end
    tests_run++; if (resp_dst_reg !== 5'd0) begin tests_failed++; $display("FAIL reset_dst: got %0d want 0", resp_dst_reg); end
  endtask

  task automatic test_divu_64();
    exp_t e; int lat;
    resp_ready = 1'b1;
    issue(64'd100, 64'd7, 1'b0, 3'd1, 1'b0, 5'd3, 64'd14, 67);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL divu_busy: got %b want 1", busy); end
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL divu_latency: got %0d want %0d", lat, e.lat); end
    tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL divu_result: got %h want %h", result, e.res); end
    tests_run++; if (resp_dst_reg !== e.dst) begin tests_failed++; $display("FAIL divu_dst: got %0d want %0d", resp_dst_reg, e.dst); end
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL divu_return_idle: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_word_ops();
    exp_t e; int lat;
    resp_ready = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 3'd0, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 35);
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL remw_latency: got %0d want %0d", lat, e.lat); end
    tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL remw_result: got %h want %h", result, e.res); end
    @(negedge clk);
    issue(64'h0000_0000_8000_0000, 64'd1, 1'b1, 3'd1, 1'b0, 5'd8, 64'hFFFF_FFFF_8000_0000, 35);
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL divuw_latency: got %0d want %0d", lat, e.lat); end
    tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL divuw_result: got %h want %h", result, e.res); end
    tests_run++; if (resp_dst_reg !== e.dst) begin tests_failed++; $display("FAIL divuw_dst: got %0d want %0d", resp_dst_reg, e.dst); end
    @(negedge clk);
  endtask

  task automatic test_special_cases();
    exp_t e; int lat;
    logic [63:0] a_v [4];
    logic [63:0] b_v [4];
    logic        r_v [4];
    logic [63:0] x_v [4];
    a_v[0] = 64'd12345;               b_v[0] = 64'd0;                   r_v[0] = 1'b0; x_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    a_v[1] = 64'd12345;               b_v[1] = 64'd0;                   r_v[1] = 1'b1; x_v[1] = 64'd12345;
    a_v[2] = 64'h8000_0000_0000_0000; b_v[2] = 64'hFFFF_FFFF_FFFF_FFFF; r_v[2] = 1'b0; x_v[2] = 64'h8000_0000_0000_0000;
    a_v[3] = 64'h8000_0000_0000_0000; b_v[3] = 64'hFFFF_FFFF_FFFF_FFFF; r_v[3] = 1'b1; x_v[3] = 64'h0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(a_v[i], b_v[i], 1'b0, 3'd0, r_v[i], 5'(10 + i), x_v[i], 2);
      wait_valid(lat);
      e = exp_q.pop_front();
      tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL special%0d_latency: got %0d want %0d", i, lat, e.lat); end
      tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL special%0d_result: got %h want %h", i, result, e.res); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    exp_t e; int lat;
    resp_ready = 1'b1;
    issue(64'd1000, 64'd10, 1'b0, 3'd0, 1'b0, 5'd20, 64'd100, 67);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_front());
    tests_run++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_idle: got ready=%b busy=%b valid=%b want 1 0 0", req_ready, busy, resp_valid); end
    issue(64'd50, 64'd5, 1'b0, 3'd0, 1'b0, 5'd21, 64'd10, 67);
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL flush_new_latency: got %0d want %0d", lat, e.lat); end
    tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL flush_new_result: got %h want %h", result, e.res); end
    tests_run++; if (resp_dst_reg !== e.dst) begin tests_failed++; $display("FAIL flush_new_dst: got %0d want %0d", resp_dst_reg, e.dst); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e; exp_t e2; int lat;
    resp_ready = 1'b0;
    issue(64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 3'd0, 1'b0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFA, 67);
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL bp_latency: got %0d want %0d", lat, e.lat); end
    dividend = 64'd9; divisor = 64'd3; is_word_op = 1'b0; unsigned_op = 3'd1;
    want_rem = 1'b0; dst_reg = 5'd9; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (resp_valid !== 1'b1 || result !== e.res || req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_hold%0d: got valid=%b result=%h ready=%b want 1 %h 0", i, resp_valid, result, req_ready, e.res); end
      if (i < 5) @(negedge clk);
    end
    tests_run++; if (resp_dst_reg !== e.dst) begin tests_failed++; $display("FAIL bp_dst: got %0d want %0d", resp_dst_reg, e.dst); end
    resp_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_after_handshake: got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    @(posedge clk);
    e2.res = 64'd3; e2.dst = 5'd9; e2.lat = 67;
    exp_q.push_back(e2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL bp_next_latency: got %0d want %0d", lat, e.lat); end
    tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL bp_next_result: got %h want %h", result, e.res); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_random();
    exp_t e; int lat;
    logic [63:0] a, b;
    logic        w, r;
    logic [2:0]  u;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      u = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
      if (i % 3 == 0) b = 64'($urandom_range(1, 1000));
      if (i == 4) b = {32'hDEAD_BEEF, 32'h0};
      if (i == 7) begin
        u = 3'd6;
        a = w ? 64'h1234_5678_8000_0000 : 64'h8000_0000_0000_0000;
        b = w ? 64'hABCD_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      end
      issue(a, b, w, u, r, 5'(i), ref_div(a, b, w, u, r), ref_lat(a, b, w, u));
      wait_valid(lat);
      e = exp_q.pop_front();
      tests_run++; if (lat !== e.lat) begin tests_failed++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, e.lat); end
      tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL rand%0d_result: a=%h b=%h w=%b u=%0d r=%b got %h want %h", i, a, b, w, u, r, result, e.res); end
      tests_run++; if (resp_dst_reg !== e.dst) begin tests_failed++; $display("FAIL rand%0d_dst: got %0d want %0d", i, resp_dst_reg, e.dst); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat;
    resp_ready = 1'b1;
    issue(64'd999, 64'd9, 1'b0, 3'd0, 1'b0, 5'd30, 64'd111, 67);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_front());
    tests_run++; if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 64'h0) begin tests_failed++; $display("FAIL reset_run: got busy=%b ready=%b valid=%b result=%h want 0 1 0 0", busy, req_ready, resp_valid, result); end
    reset = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    issue(64'd5, 64'd0, 1'b0, 3'd1, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    wait_valid(lat);
    e = exp_q.pop_front();
    tests_run++; if (result !== e.res) begin tests_failed++; $display("FAIL reset_done_pre: got %h want %h", result, e.res); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (resp_valid !== 1'b0 || result !== 64'h0 || resp_dst_reg !== 5'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got valid=%b result=%h dst=%0d busy=%b want 0 0 0 0", resp_valid, result, resp_dst_reg, busy); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_done_after: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divu_64();
    test_word_ops();
    test_special_cases();
    test_flush();
    test_backpressure();
    test_back_to_back_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
